// File: rtl/zap_ram_pkg.sv
// Shared constants and the byte-lane merge helper for the pipelined byte-enable RAM.
// byte_merge works at the maximum supported width; callers cast to and from their own width.
package zap_ram_pkg;

    localparam int ZAP_RAM_MAX_LATENCY = 4;
    localparam int ZAP_RAM_MAX_WIDTH   = 512;

    function automatic logic [ZAP_RAM_MAX_WIDTH-1:0] byte_merge(
        input logic [ZAP_RAM_MAX_WIDTH-1:0]   oldWord,
        input logic [ZAP_RAM_MAX_WIDTH-1:0]   newWord,
        input logic [ZAP_RAM_MAX_WIDTH/8-1:0] be
    );
        logic [ZAP_RAM_MAX_WIDTH-1:0] merged;
        merged = oldWord;
        for (int k = 0; k < ZAP_RAM_MAX_WIDTH/8; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = newWord[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/zap_ram_pipe_be_if.sv
// Write/read port bundle of the pipelined byte-enable RAM.
// The master modport drives requests; the slave modport is the RAM side.
interface zap_ram_pipe_be_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic               i_clken;
    logic               i_wr_en;
    logic [WIDTH/8-1:0] i_wr_be;
    logic [AW-1:0]      i_wr_addr;
    logic [WIDTH-1:0]   i_wr_data;
    logic               i_rd_en;
    logic [AW-1:0]      i_rd_addr;
    logic               o_rd_valid;
    logic [WIDTH-1:0]   o_rd_data;

    modport master (
        output i_clken, i_wr_en, i_wr_be, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
        input  o_rd_valid, o_rd_data
    );

    modport slave (
        input  i_clken, i_wr_en, i_wr_be, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
        output o_rd_valid, o_rd_data
    );

endinterface

// File: rtl/zap_ram_fwd_stage.sv
// One read-pipeline register {valid, addr, data} that folds in same-address writes from the live
// write port, so data leaving the last stage already reflects every write made while in flight.
module zap_ram_fwd_stage
    import zap_ram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clken_i,
    input  logic               validIn_i,
    input  logic [AW-1:0]      addrIn_i,
    input  logic [WIDTH-1:0]   dataIn_i,
    input  logic               wrEn_i,
    input  logic [WIDTH/8-1:0] wrBe_i,
    input  logic [AW-1:0]      wrAddr_i,
    input  logic [WIDTH-1:0]   wrData_i,
    output logic               valid_o,
    output logic [AW-1:0]      addr_o,
    output logic [WIDTH-1:0]   data_o
);

    logic             valid_q, valid_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             wrHit;

    assign wrHit = wrEn_i && (wrAddr_i == addrIn_i);

    // Address and data only load with a live read so the output holds its last result when idle.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (clken_i) begin
            valid_d = validIn_i;
            if (validIn_i) begin
                addr_d = addrIn_i;
                if (wrHit) begin
                    data_d = WIDTH'(byte_merge(ZAP_RAM_MAX_WIDTH'(dataIn_i),
                                               ZAP_RAM_MAX_WIDTH'(wrData_i),
                                               (ZAP_RAM_MAX_WIDTH/8)'(wrBe_i)));
                end else begin
                    data_d = dataIn_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/zap_ram_pipe_be.sv
// Pipelined 1W/1R RAM with byte-lane writes and LATENCY-cycle reads; the array is read-first and
// every pipeline stage merges matching writes so results stay coherent with in-flight writes.
module zap_ram_pipe_be
    import zap_ram_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    zap_ram_pipe_be_if.slave ramBus
);

    localparam int AW = $clog2(DEPTH);

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > ZAP_RAM_MAX_WIDTH) begin : gBadWidth
        $error("zap_ram_pipe_be: WIDTH must be a non-zero multiple of 8 up to %0d", ZAP_RAM_MAX_WIDTH);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("zap_ram_pipe_be: DEPTH must be a power of 2 and at least 2");
    end
    if (LATENCY < 1 || LATENCY > ZAP_RAM_MAX_LATENCY) begin : gBadLatency
        $error("zap_ram_pipe_be: LATENCY must be in 1..%0d", ZAP_RAM_MAX_LATENCY);
    end

    logic [WIDTH-1:0] memArray [DEPTH];
    logic             wrActive;

    assign wrActive = ramBus.i_clken && !i_reset && ramBus.i_wr_en;

    // The array is never reset; contents survive i_reset.
    always_ff @(posedge i_clk) begin
        if (wrActive) begin
            for (int k = 0; k < WIDTH/8; k++) begin
                if (ramBus.i_wr_be[k]) begin
                    memArray[ramBus.i_wr_addr][8*k +: 8] <= ramBus.i_wr_data[8*k +: 8];
                end
            end
        end
    end

    logic             stageValid [LATENCY+1];
    logic [AW-1:0]    stageAddr  [LATENCY+1];
    logic [WIDTH-1:0] stageData  [LATENCY+1];

    assign stageValid[0] = ramBus.i_rd_en;
    assign stageAddr[0]  = ramBus.i_rd_addr;
    assign stageData[0]  = memArray[ramBus.i_rd_addr];

    for (genvar s = 0; s < LATENCY; s++) begin : gStage
        zap_ram_fwd_stage #(
            .WIDTH (WIDTH),
            .AW    (AW)
        ) uStage (
            .clk_i     (i_clk),
            .reset_i   (i_reset),
            .clken_i   (ramBus.i_clken),
            .validIn_i (stageValid[s]),
            .addrIn_i  (stageAddr[s]),
            .dataIn_i  (stageData[s]),
            .wrEn_i    (ramBus.i_wr_en),
            .wrBe_i    (ramBus.i_wr_be),
            .wrAddr_i  (ramBus.i_wr_addr),
            .wrData_i  (ramBus.i_wr_data),
            .valid_o   (stageValid[s+1]),
            .addr_o    (stageAddr[s+1]),
            .data_o    (stageData[s+1])
        );
    end

    assign ramBus.o_rd_valid = stageValid[LATENCY];
    assign ramBus.o_rd_data  = stageData[LATENCY];

endmodule
